sdram_init_refresh: RTL and testbench



---
 rtl/sdram_init_refresh_if.sv | 34 +++
 rtl/sdram_init_refresh.sv | 204 ++++++++++++++++++++
 tb/tb_sdram_init_refresh.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_init_refresh_if.sv
// Command/address bus and refresh handshake between the init/refresh
// sequencer (master) and the downstream SDRAM command path (slave).
interface sdram_init_refresh_if;
    logic        ref_grant;
    logic        cke;
    logic [3:0]  cmd;
    logic [11:0] maddr;
    logic        bus_own;
    logic        init_done;
    logic        ref_req;
    logic        ref_overrun;

    modport master (
        input  ref_grant,
        output cke,
        output cmd,
        output maddr,
        output bus_own,
        output init_done,
        output ref_req,
        output ref_overrun
    );

    modport slave (
        output ref_grant,
        input  cke,
        input  cmd,
        input  maddr,
        input  bus_own,
        input  init_done,
        input  ref_req,
        input  ref_overrun
    );
endinterface

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init sequencer and periodic refresh scheduler for the
// Zorro II fast-RAM SDRAM. Owns the command bus during init and during each
// granted refresh; otherwise hands it to the RAM-cycle logic.
// Optional build macro REFRESH_BURST_EN: drain the whole refresh backlog in
// one bus-ownership window while ref_grant stays high.
// T_RP, T_RC and T_MRD must be at least 2.
module sdram_init_refresh #(
    parameter int unsigned INIT_WAIT        = 10000,
    parameter int unsigned INIT_REFRESHES   = 8,
    parameter int unsigned REFRESH_INTERVAL = 780,
    parameter int unsigned T_RP             = 2,
    parameter int unsigned T_RC             = 7,
    parameter int unsigned T_MRD            = 2,
    parameter logic [11:0] MODE_WORD        = 12'h020
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    sdram_init_refresh_if.master      sd
);

    localparam int unsigned MAX_A   = (INIT_WAIT > T_RC) ? INIT_WAIT : T_RC;
    localparam int unsigned MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int unsigned IREF_W  = $clog2(INIT_REFRESHES + 1);

    localparam logic [3:0]  CMD_NOP = 4'b0111;
    localparam logic [3:0]  CMD_PRE = 4'b0010;
    localparam logic [3:0]  CMD_REF = 4'b0001;
    localparam logic [3:0]  CMD_MRS = 4'b0000;
    localparam logic [11:0] ADDR_A10 = 12'h400;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_TRP,
        ST_INIT_REF,
        ST_INIT_TRC,
        ST_INIT_MRS,
        ST_INIT_TMRD,
        ST_IDLE,
        ST_REF_WAIT,
        ST_REF_CMD,
        ST_REF_TRC
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [IREF_W-1:0]  init_refs;
    logic [TMR_W-1:0]   ref_tmr;
    logic [1:0]         backlog;
    logic               cke_q;
    logic [3:0]         cmd_q;
    logic [11:0]        maddr_q;
    logic               bus_own_q;
    logic               init_done_q;
    logic               overrun_q;
    logic               tmr_wrap;
    logic               ref_issue;

    assign tmr_wrap  = init_done_q && (ref_tmr == TMR_W'(REFRESH_INTERVAL - 1));
    assign ref_issue = (state == ST_REF_CMD);

    assign sd.cke         = cke_q;
    assign sd.cmd         = cmd_q;
    assign sd.maddr       = maddr_q;
    assign sd.bus_own     = bus_own_q;
    assign sd.init_done   = init_done_q;
    assign sd.ref_req     = (backlog != 2'd0) && init_done_q;
    assign sd.ref_overrun = overrun_q;

    // Init/refresh sequencer; command and address registered alongside each transition.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= ST_INIT_WAIT;
            wait_cnt    <= '0;
            init_refs   <= '0;
            cke_q       <= 1'b0;
            cmd_q       <= CMD_NOP;
            maddr_q     <= '0;
            bus_own_q   <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            cke_q   <= 1'b1;
            cmd_q   <= CMD_NOP;
            maddr_q <= '0;
            case (state)
                ST_INIT_WAIT: begin
                    if (wait_cnt == CNT_W'(INIT_WAIT)) begin
                        state   <= ST_INIT_PRE;
                        cmd_q   <= CMD_PRE;
                        maddr_q <= ADDR_A10;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_INIT_PRE: begin
                    state    <= ST_INIT_TRP;
                    wait_cnt <= '0;
                end
                ST_INIT_TRP: begin
                    if (wait_cnt == CNT_W'(T_RP - 2)) begin
                        state <= ST_INIT_REF;
                        cmd_q <= CMD_REF;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_INIT_REF: begin
                    state     <= ST_INIT_TRC;
                    wait_cnt  <= '0;
                    init_refs <= init_refs + IREF_W'(1);
                end
                ST_INIT_TRC: begin
                    if (wait_cnt == CNT_W'(T_RC - 2)) begin
                        if (init_refs == IREF_W'(INIT_REFRESHES)) begin
                            state   <= ST_INIT_MRS;
                            cmd_q   <= CMD_MRS;
                            maddr_q <= MODE_WORD;
                        end else begin
                            state <= ST_INIT_REF;
                            cmd_q <= CMD_REF;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_INIT_MRS: begin
                    state    <= ST_INIT_TMRD;
                    wait_cnt <= '0;
                end
                ST_INIT_TMRD: begin
                    if (wait_cnt == CNT_W'(T_MRD - 2)) begin
                        state       <= ST_IDLE;
                        init_done_q <= 1'b1;
                        bus_own_q   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (backlog != 2'd0) begin
                        state <= ST_REF_WAIT;
                    end
                end
                ST_REF_WAIT: begin
                    if (sd.ref_grant) begin
                        state     <= ST_REF_CMD;
                        bus_own_q <= 1'b1;
                        cmd_q     <= CMD_REF;
                    end
                end
                ST_REF_CMD: begin
                    state    <= ST_REF_TRC;
                    wait_cnt <= '0;
                end
                ST_REF_TRC: begin
                    if (wait_cnt == CNT_W'(T_RC - 2)) begin
`ifdef REFRESH_BURST_EN
                        if ((backlog != 2'd0) && sd.ref_grant) begin
                            state <= ST_REF_CMD;
                            cmd_q <= CMD_REF;
                        end else begin
                            state     <= ST_IDLE;
                            bus_own_q <= 1'b0;
                        end
`else
                        state     <= ST_IDLE;
                        bus_own_q <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT_WAIT;
                end
            endcase
        end
    end

    // Refresh interval timer, owed-refresh backlog and sticky overrun flag.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ref_tmr   <= '0;
            backlog   <= 2'd0;
            overrun_q <= 1'b0;
        end else begin
            if (init_done_q) begin
                ref_tmr <= tmr_wrap ? '0 : ref_tmr + TMR_W'(1);
            end
            if (tmr_wrap && (backlog == 2'd3)) begin
                overrun_q <= 1'b1;
            end
            case ({tmr_wrap, ref_issue})
                2'b10: if (backlog != 2'd3) backlog <= backlog + 2'd1;
                2'b01: if (backlog != 2'd0) backlog <= backlog - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh with shortened timing parameters.
// Cycle n is the state observed after the n-th rising CLK edge following
// reset release; cycle 0 is the reset state.
module tb_sdram_init_refresh;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;

    logic CLK;
    logic RESET_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    sdram_init_refresh_if sd ();

    sdram_init_refresh #(
        .INIT_WAIT        (20),
        .INIT_REFRESHES   (2),
        .REFRESH_INTERVAL (16),
        .T_RP             (2),
        .T_RC             (3),
        .T_MRD            (2),
        .MODE_WORD        (12'h020)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .sd      (sd)
    );

    typedef struct {
        int          cyc;
        logic        grant;
        logic        cke;
        logic        own;
        logic        done;
        logic        req;
        logic [3:0]  cmd;
        logic [11:0] amask;
        logic [11:0] addr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle index since reset release.
    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic do_reset(input logic grant);
        @(negedge CLK);
        RESET_n = 1'b0;
        sd.ref_grant = grant;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    task automatic add_vec(input int c, input logic g, input logic cke, input logic own,
                           input logic done, input logic req, input logic [3:0] cmd,
                           input logic [11:0] amask, input logic [11:0] addr);
        vec_t v;
        v.cyc = c; v.grant = g; v.cke = cke; v.own = own; v.done = done;
        v.req = req; v.cmd = cmd; v.amask = amask; v.addr = addr;
        vecs.push_back(v);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            go(vecs[i].cyc);
            sd.ref_grant = vecs[i].grant;
            chk("cke",       32'(sd.cke),         32'(vecs[i].cke));
            chk("bus_own",   32'(sd.bus_own),     32'(vecs[i].own));
            chk("init_done", 32'(sd.init_done),   32'(vecs[i].done));
            chk("ref_req",   32'(sd.ref_req),     32'(vecs[i].req));
            chk("overrun",   32'(sd.ref_overrun), 32'd0);
            if (vecs[i].own) chk("cmd", 32'(sd.cmd), 32'(vecs[i].cmd));
            if (vecs[i].amask != 12'h000) chk("maddr", 32'(sd.maddr & vecs[i].amask), 32'(vecs[i].addr));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int refs;
        int wins;
        logic prev_own;
        n_checks = 0;
        n_errors = 0;
        RESET_n = 1'b0;
        sd.ref_grant = 1'b1;

        // cyc  grant cke own done req cmd  amask   addr
        add_vec( 0, 1, 0, 1, 0, 0, NOP, 12'hFFF, 12'h000);
        add_vec( 1, 1, 1, 1, 0, 0, NOP, 12'h000, 12'h000);
        add_vec(20, 1, 1, 1, 0, 0, NOP, 12'h000, 12'h000);
        add_vec(21, 1, 1, 1, 0, 0, PRE, 12'h400, 12'h400);
        add_vec(22, 1, 1, 1, 0, 0, NOP, 12'h000, 12'h000);
        add_vec(23, 1, 1, 1, 0, 0, REF, 12'h000, 12'h000);
        add_vec(24, 1, 1, 1, 0, 0, NOP, 12'h000, 12'h000);
        add_vec(26, 1, 1, 1, 0, 0, REF, 12'h000, 12'h000);
        add_vec(28, 1, 1, 1, 0, 0, NOP, 12'h000, 12'h000);
        add_vec(29, 1, 1, 1, 0, 0, MRS, 12'hFFF, 12'h020);
        add_vec(30, 1, 1, 1, 0, 0, NOP, 12'h000, 12'h000);
        add_vec(31, 1, 1, 0, 1, 0, NOP, 12'h000, 12'h000);
        add_vec(46, 1, 1, 0, 1, 0, NOP, 12'h000, 12'h000);
        add_vec(47, 1, 1, 0, 1, 1, NOP, 12'h000, 12'h000);
        add_vec(48, 1, 1, 0, 1, 1, NOP, 12'h000, 12'h000);
        add_vec(49, 1, 1, 1, 1, 1, REF, 12'h000, 12'h000);
        add_vec(50, 1, 1, 1, 1, 0, NOP, 12'h000, 12'h000);
        add_vec(51, 1, 1, 1, 1, 0, NOP, 12'h000, 12'h000);
        add_vec(52, 1, 1, 0, 1, 0, NOP, 12'h000, 12'h000);
        add_vec(62, 1, 1, 0, 1, 0, NOP, 12'h000, 12'h000);
        add_vec(63, 1, 1, 0, 1, 1, NOP, 12'h000, 12'h000);
        add_vec(65, 1, 1, 1, 1, 1, REF, 12'h000, 12'h000);

        // Init sequence and basic refresh with grant held high.
        do_reset(1'b1);
        run_table();

        // Reset pulled in the middle of REF_TRC.
        go(66);
        chk("trc_own", 32'(sd.bus_own), 32'd1);
        chk("trc_cmd", 32'(sd.cmd), 32'(NOP));
        RESET_n = 1'b0;
        #1;
        chk("rst_own",  32'(sd.bus_own),   32'd1);
        chk("rst_done", 32'(sd.init_done), 32'd0);
        chk("rst_cmd",  32'(sd.cmd),       32'(NOP));
        chk("rst_cke",  32'(sd.cke),       32'd0);
        chk("rst_req",  32'(sd.ref_req),   32'd0);
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        run_table();

        // Timer wrap coinciding with REF_CMD while backlog is 1.
        do_reset(1'b0);
        go(47);
        chk("sim_req47", 32'(sd.ref_req), 32'd1);
        go(61);
        chk("sim_own61", 32'(sd.bus_own), 32'd0);
        sd.ref_grant = 1'b1;
        go(62);
        chk("sim_cmd62", 32'(sd.cmd), 32'(REF));
        chk("sim_own62", 32'(sd.bus_own), 32'd1);
        sd.ref_grant = 1'b0;
        go(63);
        chk("sim_req63", 32'(sd.ref_req), 32'd1);
        chk("sim_own63", 32'(sd.bus_own), 32'd1);
        go(64);
        chk("sim_own64", 32'(sd.bus_own), 32'd1);
        go(65);
        chk("sim_own65", 32'(sd.bus_own), 32'd0);
        chk("sim_req65", 32'(sd.ref_req), 32'd1);
        go(67);
        chk("sim_own67", 32'(sd.bus_own), 32'd0);
        chk("sim_req67", 32'(sd.ref_req), 32'd1);

        // Backlog saturation, overrun, then draining the backlog.
        do_reset(1'b0);
        go(47);
        chk("ovr47", 32'(sd.ref_overrun), 32'd0);
        go(63);
        chk("ovr63", 32'(sd.ref_overrun), 32'd0);
        go(79);
        chk("ovr79", 32'(sd.ref_overrun), 32'd0);
        go(94);
        chk("ovr94", 32'(sd.ref_overrun), 32'd0);
        chk("req94", 32'(sd.ref_req), 32'd1);
        go(95);
        chk("ovr95", 32'(sd.ref_overrun), 32'd1);
        chk("own95", 32'(sd.bus_own), 32'd0);
        sd.ref_grant = 1'b1;
        refs = 0;
        wins = 0;
        prev_own = 1'b0;
        for (int c = 96; c <= 110; c++) begin
            go(c);
            if (sd.bus_own && !prev_own) wins++;
            if (sd.bus_own && (sd.cmd == REF)) refs++;
            prev_own = sd.bus_own;
        end
        chk("drain_refs", 32'(refs), 32'd3);
`ifdef REFRESH_BURST_EN
        chk("drain_windows", 32'(wins), 32'd1);
`else
        chk("drain_windows", 32'(wins), 32'd3);
`endif
        chk("req110", 32'(sd.ref_req), 32'd0);
        chk("own110", 32'(sd.bus_own), 32'd0);
        chk("ovr110", 32'(sd.ref_overrun), 32'd1);
        go(111);
        chk("req111", 32'(sd.ref_req), 32'd1);
        chk("ovr111", 32'(sd.ref_overrun), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
